// File: rtl/lock_pkg.sv
// Shared types and helpers for the key-locked adder: FSM state encoding and
// the key-derived result mask.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    CHECK  = 2'd1,
    OPEN   = 2'd2,
    DEAD   = 2'd3
  } lock_state_e;

  localparam int unsigned LOCK_MAX_KEY_W = 256;
  localparam int unsigned LOCK_MAX_W     = 1024;

  // Key repeated from the LSB up to width bits; bits above width stay zero.
  function automatic logic [LOCK_MAX_W-1:0] lock_mask(
    input logic [LOCK_MAX_KEY_W-1:0] key,
    input int unsigned               key_w,
    input int unsigned               width
  );
    logic [LOCK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < LOCK_MAX_W; i++) begin
      if (i < width) m[10'(i)] = key[8'(i % key_w)];
    end
    return m;
  endfunction

endpackage

// File: rtl/lock_fsm.sv
// Key handshake and lock state machine. Optional wrong-key lockout is
// enabled with the LOCK_LOCKOUT_EN macro.
module lock_fsm
  import lock_pkg::*;
#(
  parameter int unsigned          KEY_W     = 48,
  parameter logic [KEY_W-1:0]     KEY       = 48'h756E4C30634B,
  parameter int unsigned          MAX_TRIES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_data,
  output logic             key_ready,
  output logic             open,
  output logic             dead
);

  lock_state_e      state, state_next;
  logic [KEY_W-1:0] key_q;
  logic             key_match;
  logic             last_try;

  assign key_match = (key_q == KEY);

`ifdef LOCK_LOCKOUT_EN
  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

  logic [TRIES_W-1:0] tries;
  logic [TRIES_W-1:0] tries_inc;

  assign tries_inc = (tries == TRIES_W'(MAX_TRIES)) ? tries : tries + 1'b1;
  assign last_try  = (tries_inc == TRIES_W'(MAX_TRIES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tries <= '0;
    end else if (state == CHECK) begin
      tries <= key_match ? '0 : tries_inc;
    end
  end
`else
  assign last_try = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOCKED;
      key_q <= '0;
    end else begin
      state <= state_next;
      if (state == LOCKED && key_valid) key_q <= key_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOCKED:  if (key_valid) state_next = CHECK;
      CHECK: begin
        if (key_match)     state_next = OPEN;
        else if (last_try) state_next = DEAD;
        else               state_next = LOCKED;
      end
      OPEN:    state_next = OPEN;
      DEAD:    state_next = DEAD;
      default: state_next = LOCKED;
    endcase
  end

  assign key_ready = (state == LOCKED);
  assign open      = (state == OPEN);
`ifdef LOCK_LOCKOUT_EN
  assign dead      = (state == DEAD);
`else
  assign dead      = 1'b0;
`endif

endmodule

// File: rtl/locked_add_pipe.sv
// Key-locked registered adder: sum is masked until the lock FSM opens.
// Wrong-key lockout is enabled by defining LOCK_LOCKOUT_EN.
module locked_add_pipe
  import lock_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      KEY_W     = 48,
  parameter logic [KEY_W-1:0] KEY       = 48'h756E4C30634B,
  parameter int unsigned      MAX_TRIES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_data,
  output logic             key_ready,
  output logic             unlocked,
  output logic             lockout,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MASK =
    WIDTH'(lock_mask(LOCK_MAX_KEY_W'(KEY), KEY_W, WIDTH));

  logic           open;
  logic           dead;
  logic           accept;
  logic [WIDTH:0] full_sum;

  lock_fsm #(
    .KEY_W     (KEY_W),
    .KEY       (KEY),
    .MAX_TRIES (MAX_TRIES)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .open      (open),
    .dead      (dead)
  );

  assign unlocked = open;
  assign lockout  = dead;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign full_sum = {1'b0, a} + {1'b0, b};

  // Lock mode is captured with the operands, so a held result never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      sum       <= open ? full_sum[WIDTH-1:0] : (full_sum[WIDTH-1:0] ^ MASK);
      carry     <= open ? full_sum[WIDTH] : ~full_sum[WIDTH];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_locked_add_pipe.sv
// Scoreboard bench for locked_add_pipe (default parameters).
module tb_locked_add_pipe;

  localparam logic [47:0] GOOD_KEY = 48'h756E4C30634B;
  localparam logic [31:0] MASK32   = 32'h4C30634B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [47:0] key_data;
  logic        key_ready;
  logic        unlocked;
  logic        lockout;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  locked_add_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] expv(input logic [31:0] x, input logic [31:0] y,
                                       input bit open_exp);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    return open_exp ? s : {~s[32], s[31:0] ^ MASK32};
  endfunction

  // Compare every result taken by the consumer against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected: got carry=%b sum=%h with nothing expected", carry, sum);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({carry, sum} !== e) begin
          fails++;
          $display("FAIL result: got carry=%b sum=%h required carry=%b sum=%h",
                   carry, sum, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic check1(input string name, input logic got, input logic req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input bit open_exp);
    int n = 0;
    in_valid = 1'b1; a = x; b = y;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_accept: in_ready=%b required 1", in_ready);
    end else begin
      exp_q.push_back(expv(x, y, open_exp));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic present_key(input logic [47:0] k);
    int n = 0;
    key_valid = 1'b1; key_data = k;
    @(negedge clk);
    while (!key_ready && n < 20) begin n++; @(negedge clk); end
    check1("key_accept", key_ready, 1'b1);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin n++; @(negedge clk); end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key_valid = 1'b0; key_data = '0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b1;
    #12;
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_carry", carry, 1'b0);
    tests++;
    if (sum !== 32'h0) begin fails++; $display("FAIL rst_sum: got %h required 0", sum); end
    check1("rst_unlocked", unlocked, 1'b0);
    check1("rst_lockout", lockout, 1'b0);
    check1("rst_key_ready", key_ready, 1'b1);
    check1("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_locked_sum;
    send(32'd2, 32'd3, 1'b0);
    check1("locked_unlocked", unlocked, 1'b0);
    drain();
  endtask

  task automatic test_unlock;
    present_key(GOOD_KEY);
    // Operands accepted on the CHECK edge must still be masked.
    in_valid = 1'b1; a = 32'd9; b = 32'd1;
    exp_q.push_back(expv(32'd9, 32'd1, 1'b0));
    @(negedge clk);
    check1("check_unlocked", unlocked, 1'b0);
    check1("check_key_ready", key_ready, 1'b0);
    check1("check_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check1("open_unlocked", unlocked, 1'b1);
    @(posedge clk); #1;
    send(32'd2, 32'd3, 1'b1);
    send(32'd4, 32'd7, 1'b1);
    drain();
  endtask

  task automatic test_max;
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] x, y;
      x = $urandom; y = $urandom;
      send(x, y, 1'b1);
    end
    drain();
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    send(32'd10, 32'd20, 1'b1);
    in_valid = 1'b1; a = 32'd100; b = 32'd200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("stall_out_valid", out_valid, 1'b1);
      check1("stall_in_ready", in_ready, 1'b0);
      tests++;
      if (sum !== 32'd30 || carry !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold: got carry=%b sum=%h required carry=0 sum=0000001e", carry, sum);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check1("release_in_ready", in_ready, 1'b1);
    exp_q.push_back(expv(32'd100, 32'd200, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check1("mid_held", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("mid_out_valid", out_valid, 1'b0);
    check1("mid_unlocked", unlocked, 1'b0);
    check1("mid_lockout", lockout, 1'b0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'd2, 32'd3, 1'b0);
    drain();
  endtask

  task automatic test_wrong_keys;
    present_key(48'h0);
    @(posedge clk); #1;
    present_key(48'h0);
    @(posedge clk); #1;
    check1("two_wrong_lockout", lockout, 1'b0);
    check1("two_wrong_key_ready", key_ready, 1'b1);
    present_key(48'h0);
    @(posedge clk); #1;
`ifdef LOCK_LOCKOUT_EN
    check1("dead_lockout", lockout, 1'b1);
    key_valid = 1'b1; key_data = GOOD_KEY;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("dead_key_ready", key_ready, 1'b0);
      check1("dead_unlocked", unlocked, 1'b0);
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    send(32'd2, 32'd3, 1'b0);
`else
    check1("nolock_lockout", lockout, 1'b0);
    check1("nolock_key_ready", key_ready, 1'b1);
    present_key(GOOD_KEY);
    @(posedge clk); #1;
    check1("nolock_unlocked", unlocked, 1'b1);
    send(32'd2, 32'd3, 1'b1);
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_locked_sum();
    test_unlock();
    test_max();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wrong_keys();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
